// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader_if
// Purpose  : Bundles the host byte stream, load control and instruction
//            memory write port of the instruction memory loader.
// Modports : slave  - the loader (consumes start/bytes, drives memory port)
//            master - the host/environment side
// Signals  : start, word_count      load request and its length in words
//            byte_in, byte_valid,   byte stream with ready handshake
//            byte_ready
//            we, waddr, wdata       instruction memory write port
//            busy, done, err,       load status
//            checksum, core_nrst
// Revision : 1.0 - initial release
// ============================================================================
interface inst_mem_loader_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       checksum;
  logic              core_nrst;

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, we, waddr, wdata, busy, done, err, checksum, core_nrst
  );

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, we, waddr, wdata, busy, done, err, checksum, core_nrst
  );
endinterface
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader
// Purpose  : Receives a program as a byte stream, packs little-endian 32-bit
//            words and writes them to consecutive instruction memory word
//            addresses starting at 0. Holds the core in reset while loading.
// Ports    : CLK   - clock
//            NRST  - asynchronous active-low reset
//            bus   - inst_mem_loader_if.slave (load control, byte stream,
//                    memory write port, status)
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input wire CLK,
  input wire NRST,
  inst_mem_loader_if.slave bus
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;        // bytes 0..2 of the word being received
  logic [ADDR_W-1:0] r_word_idx;
  logic [ADDR_W:0]   r_word_count;
  logic              r_byte_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_checksum;
  logic              r_core_nrst;

  logic w_byte_acc;
  logic w_last_word;

  // byte_ready is only ever high in RECV, so this is the accept condition.
  assign w_byte_acc  = bus.byte_valid && r_byte_ready;
  assign w_last_word = ({1'b0, r_word_idx} == (r_word_count - C_ONE));

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= 2'd0;
      r_asm        <= 24'd0;
      r_word_idx   <= '0;
      r_word_count <= '0;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_checksum   <= 32'd0;
      r_core_nrst  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Core leaves reset on the first edge after NRST release.
          r_core_nrst <= 1'b1;
          if (bus.start) begin
            if (bus.word_count == '0) begin
              // Empty program: complete immediately without any write.
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_err      <= 1'b0;
              r_checksum <= 32'd0;
            end else if (bus.word_count > C_DEPTH) begin
              r_state <= S_IDLE;
              r_err   <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              r_state      <= S_RECV;
              r_word_count <= bus.word_count;
              r_word_idx   <= '0;
              r_byte_cnt   <= 2'd0;
              r_checksum   <= 32'd0;
              r_done       <= 1'b0;
              r_err        <= 1'b0;
              r_busy       <= 1'b1;
              r_byte_ready <= 1'b1;
              r_core_nrst  <= 1'b0;
            end
          end
        end

        S_RECV: begin
          if (w_byte_acc) begin
            if (r_byte_cnt == 2'd3) begin
              // Fourth byte completes the word; present it to memory next cycle.
              r_wdata      <= {bus.byte_in, r_asm};
              r_waddr      <= r_word_idx;
              r_we         <= 1'b1;
              r_byte_ready <= 1'b0;
              r_byte_cnt   <= 2'd0;
              r_state      <= S_WRITE;
            end else begin
              case (r_byte_cnt)
                2'd0:    r_asm[7:0]   <= bus.byte_in;
                2'd1:    r_asm[15:8]  <= bus.byte_in;
                default: r_asm[23:16] <= bus.byte_in;
              endcase
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        S_WRITE: begin
          r_we       <= 1'b0;
          r_checksum <= r_checksum + r_wdata;
          if (w_last_word) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_core_nrst <= 1'b1;
          end else begin
            r_word_idx   <= r_word_idx + 1'b1;
            r_byte_ready <= 1'b1;
            r_state      <= S_RECV;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.we         = r_we;
  assign bus.waddr      = r_waddr;
  assign bus.wdata      = r_wdata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.checksum   = r_checksum;
  assign bus.core_nrst  = r_core_nrst;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_loader
// Purpose  : Self-checking bench for inst_mem_loader. A transaction-level
//            model (received bytes kept in a queue, words derived from byte
//            counts) predicts every output each cycle; directed scenarios add
//            literal expectations for writes and checksums.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 8192;

  typedef logic [7:0] bq_t[$];

  logic CLK  = 1'b0;
  logic NRST = 1'b0;
  always #5 CLK = ~CLK;

  inst_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .NRST (NRST),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic        m_busy, m_inwr, m_done, m_err, m_core;
  logic [31:0] m_sum, m_wdata;
  int          m_waddr, m_n;
  logic [7:0]  m_got[$];

  always @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      m_busy = 0; m_inwr = 0; m_done = 0; m_err = 0; m_core = 0;
      m_sum = 0; m_wdata = 0; m_waddr = 0; m_n = 0;
      m_got.delete();
    end else if (m_inwr) begin
      m_inwr = 0;
      m_sum  = m_sum + m_wdata;
      if (m_got.size() == 4 * m_n) begin
        m_busy = 0; m_done = 1; m_core = 1;
      end
    end else if (m_busy) begin
      if (bus.byte_valid) begin
        m_got.push_back(bus.byte_in);
        if (m_got.size() % 4 == 0) begin
          int w;
          w       = m_got.size() / 4 - 1;
          m_waddr = w;
          m_wdata = {m_got[4*w+3], m_got[4*w+2], m_got[4*w+1], m_got[4*w]};
          m_inwr  = 1;
        end
      end
    end else begin
      m_core = 1;
      if (bus.start) begin
        if (bus.word_count == 0) begin
          m_done = 1; m_err = 0; m_sum = 0;
        end else if (int'(bus.word_count) > DEPTH) begin
          m_err = 1; m_done = 0;
        end else begin
          m_n = int'(bus.word_count);
          m_got.delete();
          m_busy = 1; m_done = 0; m_err = 0; m_sum = 0; m_core = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    chk("byte_ready", bus.byte_ready, m_busy && !m_inwr);
    chk("we",         bus.we,         m_inwr);
    chk("waddr",      bus.waddr,      m_waddr);
    chk("wdata",      bus.wdata,      m_wdata);
    chk("busy",       bus.busy,       m_busy);
    chk("done",       bus.done,       m_done);
    chk("err",        bus.err,        m_err);
    chk("checksum",   bus.checksum,   m_sum);
    chk("core_nrst",  bus.core_nrst,  m_core);
  end

  // ---------------- write monitor ----------------
  int          wa_q[$];
  logic [31:0] wd_q[$];
  always @(negedge CLK) begin
    if (NRST && bus.we) begin
      wa_q.push_back(int'(bus.waddr));
      wd_q.push_back(bus.wdata);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_start(input int wc);
    @(negedge CLK);
    bus.start      = 1'b1;
    bus.word_count = (ADDR_W+1)'(wc);
    @(negedge CLK);
    bus.start      = 1'b0;
  endtask

  // gap_mode 0: back-to-back, 1: valid pattern 1,0,0,1, 2: random gaps.
  // inj_at: byte index at which a stray start(word_count=5) is pulsed.
  task automatic send_bytes(input bq_t b, input int gap_mode, input int inj_at);
    for (int i = 0; i < b.size(); i++) begin
      int   t;
      int   gaps;
      logic rdy;
      gaps = (gap_mode == 1 && i > 0) ? 2 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gaps; g++) @(negedge CLK);
      bus.byte_in    = b[i];
      bus.byte_valid = 1'b1;
      if (i == inj_at) begin
        bus.start      = 1'b1;
        bus.word_count = (ADDR_W+1)'(5);
      end
      t = 0;
      do begin
        rdy = bus.byte_ready;
        @(negedge CLK);
        bus.start = 1'b0;
        t++;
      end while (!rdy && t < 50);
      bus.byte_valid = 1'b0;
      if (!rdy) begin
        timeout("byte_accept");
        return;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (bus.busy && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (bus.busy) timeout(name);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_byte_ready"}, bus.byte_ready, 0);
    chk({name, "_we"},         bus.we,         0);
    chk({name, "_waddr"},      bus.waddr,      0);
    chk({name, "_wdata"},      bus.wdata,      0);
    chk({name, "_busy"},       bus.busy,       0);
    chk({name, "_done"},       bus.done,       0);
    chk({name, "_err"},        bus.err,        0);
    chk({name, "_checksum"},   bus.checksum,   0);
    chk({name, "_core_nrst"},  bus.core_nrst,  0);
  endtask

  task automatic check_two_word(input string name);
    chk({name, "_nwrites"}, wa_q.size(), 2);
    if (wa_q.size() >= 2) begin
      chk({name, "_w0_addr"}, wa_q[0], 0);
      chk({name, "_w0_data"}, wd_q[0], 32'h12345678);
      chk({name, "_w1_addr"}, wa_q[1], 1);
      chk({name, "_w1_data"}, wd_q[1], 32'hDEADBEEF);
    end
    chk({name, "_checksum"},       bus.checksum, 32'hF0E21567);
    chk({name, "_model_checksum"}, m_sum,        32'hF0E21567);
    chk({name, "_done"},           bus.done,     1);
    chk({name, "_core_nrst"},      bus.core_nrst, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t two, one, part, rq;
    two  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    one  = '{8'h01, 8'h00, 8'h00, 8'h00};
    part = '{8'h11, 8'h22};

    bus.start = 0; bus.word_count = '0; bus.byte_in = '0; bus.byte_valid = 0;

    // Reset state and release
    repeat (3) @(negedge CLK);
    check_all_zero("rst_hold");
    NRST = 1'b1;
    @(posedge CLK); #1;
    chk("rel_core_nrst", bus.core_nrst, 1);
    chk("rel_busy",      bus.busy,      0);

    // Mid-clock reset while idle
    repeat (2) @(negedge CLK);
    @(posedge CLK); #2 NRST = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge CLK); NRST = 1'b1;
    @(posedge CLK); #1;
    chk("rel2_core_nrst", bus.core_nrst, 1);

    // Two-word load, back-to-back
    wa_q.delete(); wd_q.delete();
    do_start(2);
    send_bytes(two, 0, -1);
    wait_idle("two_word_idle");
    @(negedge CLK);
    check_two_word("two_word");

    // Same stream with backpressure
    wa_q.delete(); wd_q.delete();
    do_start(2);
    send_bytes(two, 1, -1);
    wait_idle("bp_idle");
    @(negedge CLK);
    check_two_word("backpressure");

    // word_count = 0
    wa_q.delete(); wd_q.delete();
    do_start(0);
    chk("wc0_done",     bus.done,     1);
    chk("wc0_checksum", bus.checksum, 0);
    chk("wc0_busy",     bus.busy,     0);
    repeat (2) @(negedge CLK);
    chk("wc0_nwrites",  wa_q.size(),  0);

    // word_count = DEPTH+1 rejected, then a valid load clears err
    do_start(DEPTH + 1);
    chk("wcbig_err",  bus.err,  1);
    chk("wcbig_done", bus.done, 0);
    repeat (3) @(negedge CLK);
    chk("wcbig_byte_ready", bus.byte_ready, 0);
    wa_q.delete(); wd_q.delete();
    do_start(1);
    chk("wc1_err_clr", bus.err,  0);
    chk("wc1_busy",    bus.busy, 1);
    rq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_bytes(rq, 0, -1);
    wait_idle("wc1_idle");
    @(negedge CLK);
    chk("wc1_nwrites", wa_q.size(), 1);
    if (wa_q.size() >= 1) chk("wc1_data", wd_q[0], 32'hDDCCBBAA);
    chk("wc1_done", bus.done, 1);

    // Reset mid-load after two accepted bytes
    wa_q.delete(); wd_q.delete();
    do_start(1);
    send_bytes(part, 0, -1);
    @(posedge CLK); #2 NRST = 1'b0;
    #1 check_all_zero("rst_load");
    chk("rst_load_nwrites", wa_q.size(), 0);
    @(negedge CLK); NRST = 1'b1;
    repeat (2) @(negedge CLK);
    do_start(1);
    send_bytes(one, 0, -1);
    wait_idle("rst_reload_idle");
    @(negedge CLK);
    chk("rst_reload_nwrites", wa_q.size(), 1);
    if (wa_q.size() >= 1) begin
      chk("rst_reload_addr", wa_q[0], 0);
      chk("rst_reload_data", wd_q[0], 32'h00000001);
    end

    // Start pulse while busy is ignored
    wa_q.delete(); wd_q.delete();
    do_start(2);
    send_bytes(two, 0, 2);
    wait_idle("busy_start_idle");
    @(negedge CLK);
    check_two_word("busy_start");

    // Randomised loads
    for (int it = 0; it < 20; it++) begin
      int          n;
      int          inj;
      logic [31:0] sum;
      n = $urandom_range(1, 6);
      rq.delete();
      for (int k = 0; k < 4 * n; k++) rq.push_back(8'($urandom));
      sum = 0;
      for (int w = 0; w < n; w++)
        sum = sum + {rq[4*w+3], rq[4*w+2], rq[4*w+1], rq[4*w]};
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
      wa_q.delete(); wd_q.delete();
      do_start(n);
      send_bytes(rq, 2, inj);
      wait_idle("rand_idle");
      @(negedge CLK);
      chk("rand_checksum", bus.checksum, sum);
      chk("rand_nwrites",  wa_q.size(),  n);
      chk("rand_done",     bus.done,     1);
      if (wa_q.size() == n)
        chk("rand_last_addr", wa_q[n-1], n - 1);
    end

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
